// File: rtl/cmd_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : cmd_fetch
//  Description : Instruction-fetch stage. Walks a program counter through
//                program memory over a req/ack handshake, buffers prefetched
//                8-bit commands in a small FIFO and presents one command per
//                cycle to the kernel. Fetch stops for good on halt.
//                Optional jump support is compiled in with the macro
//                CMD_FETCH_JUMP_EN (adds Jump_i / JumpAddr_i).
//  Revision    : 1.0 - initial release
// ============================================================================
module cmd_fetch #(
    parameter int                ADDR_W   = 8,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [7:0]        NOP_CMD  = 8'h00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Halt_i,
    input  logic              Ready_i,
    output logic [7:0]        Cmd_o,
    output logic              CmdValid_o,
    output logic [ADDR_W-1:0] Pc_o,
    output logic              Halted_o,
    output logic              MemReq_o,
    output logic [ADDR_W-1:0] MemAddr_o,
    input  logic              MemAck_i,
    input  logic [7:0]        MemData_i
`ifdef CMD_FETCH_JUMP_EN
    ,
    input  logic              Jump_i,
    input  logic [ADDR_W-1:0] JumpAddr_i
`endif
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = c_PTR_W + 1;

    localparam logic [c_PTR_W-1:0] c_PTR_ONE   = c_PTR_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_DEPTH = c_CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0]  c_ADDR_ONE  = ADDR_W'(1);

    // FETCH: idle, WAIT: request out, DRAIN: halted with request out, HALT: stopped
    localparam logic [1:0] c_ST_FETCH = 2'd0;
    localparam logic [1:0] c_ST_WAIT  = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;
    localparam logic [1:0] c_ST_HALT  = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [7:0]         r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [c_CNT_W-1:0] w_count_next;
    logic [ADDR_W-1:0]  r_pc;
    logic [ADDR_W-1:0]  r_fetch_addr;
    logic [ADDR_W-1:0]  w_fetch_next;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic               r_discard;

    logic               w_jump_req;
    logic [ADDR_W-1:0]  w_jump_addr;
    logic               w_busy;
    logic               w_halted;
    logic               w_valid;
    logic               w_ack;
    logic               w_halt;
    logic               w_jump;
    logic               w_push;
    logic               w_pop;
    logic               w_flush;
    logic               w_hold;

`ifdef CMD_FETCH_JUMP_EN
    assign w_jump_req  = Jump_i;
    assign w_jump_addr = JumpAddr_i;
`else
    assign w_jump_req  = 1'b0;
    assign w_jump_addr = RESET_PC;
`endif

    assign w_busy   = (r_state == c_ST_WAIT) || (r_state == c_ST_DRAIN);
    assign w_halted = (r_state == c_ST_DRAIN) || (r_state == c_ST_HALT);
    assign w_valid  = (r_count != '0);
    // An ack only counts while a request is actually outstanding.
    assign w_ack    = MemAck_i && w_busy;
    assign w_halt   = Halt_i && !w_halted;
    // Halt beats jump; a halted fetcher ignores jumps entirely.
    assign w_jump   = w_jump_req && !w_halted && !Halt_i;
    // Data for a request issued before a jump is dropped (r_discard).
    assign w_push   = w_ack && (r_state == c_ST_WAIT) && !r_discard && !w_jump && !w_halt;
    assign w_pop    = w_valid && Ready_i && !w_jump && !w_halt;
    assign w_flush  = w_halt || w_jump;
    // Address must stay put until the outstanding request is acked.
    assign w_hold   = w_busy && !MemAck_i;

    assign Cmd_o      = w_valid ? r_mem[r_rd_ptr] : NOP_CMD;
    assign CmdValid_o = w_valid;
    assign Pc_o       = r_pc;
    assign Halted_o   = w_halted;
    assign MemReq_o   = w_busy;
    assign MemAddr_o  = r_mem_addr;

    // Next-state, FIFO occupancy and next fetch address.
    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        w_fetch_next = r_fetch_addr;

        if (w_flush) begin
            w_count_next = '0;
        end else if (w_push && !w_pop) begin
            w_count_next = r_count + c_CNT_ONE;
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - c_CNT_ONE;
        end

        if (w_jump) begin
            w_fetch_next = w_jump_addr;
        end else if (w_push) begin
            w_fetch_next = r_fetch_addr + c_ADDR_ONE;
        end

        case (r_state)
            c_ST_FETCH: begin
                if (w_halt) begin
                    w_state_next = c_ST_HALT;
                end else if (w_count_next < c_CNT_DEPTH) begin
                    w_state_next = c_ST_WAIT;
                end
            end
            c_ST_WAIT: begin
                if (w_halt) begin
                    w_state_next = MemAck_i ? c_ST_HALT : c_ST_DRAIN;
                end else if (MemAck_i && !(w_count_next < c_CNT_DEPTH)) begin
                    w_state_next = c_ST_FETCH;
                end
            end
            c_ST_DRAIN: begin
                if (MemAck_i) begin
                    w_state_next = c_ST_HALT;
                end
            end
            c_ST_HALT: begin
                w_state_next = c_ST_HALT;
            end
            default: begin
                w_state_next = c_ST_FETCH;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FIFO pointers, program counter and fetch address bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
            r_pc         <= RESET_PC;
            r_fetch_addr <= RESET_PC;
            r_mem_addr   <= RESET_PC;
            r_discard    <= 1'b0;
        end else begin
            r_count      <= w_count_next;
            r_fetch_addr <= w_fetch_next;
            if (!w_hold) begin
                r_mem_addr <= w_fetch_next;
            end

            if (w_flush) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
                end
            end

            if (w_jump) begin
                r_pc <= w_jump_addr;
            end else if (w_pop) begin
                r_pc <= r_pc + c_ADDR_ONE;
            end

            if (w_halt) begin
                r_discard <= 1'b0;
            end else if (w_jump && (r_state == c_ST_WAIT) && !MemAck_i) begin
                r_discard <= 1'b1;
            end else if (w_ack) begin
                r_discard <= 1'b0;
            end
        end
    end

    // FIFO storage; contents need no reset since occupancy gates the output.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= MemData_i;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cmd_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cmd_fetch
//  Description : Self-checking bench for cmd_fetch. A behavioural model
//                tracks the expected command stream (ROM[a] = a+1), FIFO
//                occupancy and halt/jump effects; a second instance with a
//                4-bit address space exercises address wrap.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cmd_fetch;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       Halt_i = 1'b0;
    logic       Ready_i = 1'b0;
    logic [7:0] Cmd_o;
    logic       CmdValid_o;
    logic [7:0] Pc_o;
    logic       Halted_o;
    logic       MemReq_o;
    logic [7:0] MemAddr_o;
    logic       MemAck_i;
    logic [7:0] MemData_i;
    logic       Jump_i = 1'b0;
    logic [7:0] JumpAddr_i = 8'h00;

    logic [7:0] w_cmd;
    logic       w_valid;
    logic [3:0] w_pc;
    logic       w_halted;
    logic       w_req;
    logic [3:0] w_addr;
    logic [7:0] w_data;

    cmd_fetch dut (
        .clk        (clk),
        .rst        (rst),
        .Halt_i     (Halt_i),
        .Ready_i    (Ready_i),
        .Cmd_o      (Cmd_o),
        .CmdValid_o (CmdValid_o),
        .Pc_o       (Pc_o),
        .Halted_o   (Halted_o),
        .MemReq_o   (MemReq_o),
        .MemAddr_o  (MemAddr_o),
        .MemAck_i   (MemAck_i),
        .MemData_i  (MemData_i)
`ifdef CMD_FETCH_JUMP_EN
        ,
        .Jump_i     (Jump_i),
        .JumpAddr_i (JumpAddr_i)
`endif
    );

    cmd_fetch #(.ADDR_W(4), .RESET_PC(4'hE)) dut_w (
        .clk        (clk),
        .rst        (rst),
        .Halt_i     (1'b0),
        .Ready_i    (Ready_i),
        .Cmd_o      (w_cmd),
        .CmdValid_o (w_valid),
        .Pc_o       (w_pc),
        .Halted_o   (w_halted),
        .MemReq_o   (w_req),
        .MemAddr_o  (w_addr),
        .MemAck_i   (w_req),
        .MemData_i  (w_data)
`ifdef CMD_FETCH_JUMP_EN
        ,
        .Jump_i     (1'b0),
        .JumpAddr_i (4'h0)
`endif
    );

    always #5 clk = ~clk;

    // Program memory: ROM[a] = a + 1, ack after a programmable latency.
    int  fix_lat = 0;
    int  rlat = 0;
    int  wcnt = 0;
    int  cur_lat;
    bit  rand_mode = 1'b0;
    bit  sp_ack = 1'b0;

    assign cur_lat   = rand_mode ? rlat : fix_lat;
    assign MemAck_i  = MemReq_o ? (wcnt >= cur_lat) : sp_ack;
    assign MemData_i = MemAddr_o + 8'd1;
    assign w_data    = {4'h0, w_addr} + 8'd1;

    always @(posedge clk) begin
        if (!MemReq_o || MemAck_i) wcnt <= 0;
        else                       wcnt <= wcnt + 1;
        if (MemReq_o && MemAck_i)  rlat <= $urandom_range(0, 3);
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model state
    logic [7:0] exp_pc;
    logic [7:0] exp_fetch;
    int         occ;
    bit         halted_m, drain, discard_m, exp_issue, prev_pend;
    logic [7:0] prev_addr;
    int         req_cnt;
    bit         jmp, ack;
    logic [3:0] w_exp_pc, w_exp_fetch;

    // Main model: checks this cycle against the model, then advances it.
    always @(negedge clk) begin
        if (!rst) begin
            if (MemReq_o) req_cnt++;
            if (MemReq_o && prev_pend) chk("addr_hold", MemAddr_o, prev_addr);
            if (halted_m) begin
                chk("halted", Halted_o, 1);
                chk("halt_valid", CmdValid_o, 0);
                chk("halt_cmd", Cmd_o, 8'h00);
                chk("halt_pc", Pc_o, exp_pc);
                chk("drain_req", MemReq_o, drain);
                if (drain && MemAck_i) drain = 1'b0;
            end else begin
                jmp = Jump_i && !Halt_i;
                ack = MemReq_o && MemAck_i;
                chk("not_halted", Halted_o, 0);
                chk("valid", CmdValid_o, occ != 0);
                if (CmdValid_o) begin
                    chk("pc", Pc_o, exp_pc);
                    chk("cmd", Cmd_o, exp_pc + 8'd1);
                end else begin
                    chk("nop", Cmd_o, 8'h00);
                end
                if (exp_issue) begin
                    chk("jump_issue", MemReq_o, 1);
                    chk("jump_addr", MemAddr_o, exp_fetch);
                end
                exp_issue = 1'b0;
                if (MemReq_o) chk("reserve", occ < DEPTH, 1);
                if (ack && !discard_m) chk("fetch_addr", MemAddr_o, exp_fetch);
                if (Halt_i) begin
                    halted_m  = 1'b1;
                    drain     = MemReq_o && !MemAck_i;
                    occ       = 0;
                    discard_m = 1'b0;
                end else if (jmp) begin
                    exp_pc    = JumpAddr_i;
                    exp_fetch = JumpAddr_i;
                    occ       = 0;
                    if (MemReq_o && !MemAck_i) discard_m = 1'b1;
                    else begin
                        discard_m = 1'b0;
                        exp_issue = 1'b1;
                    end
                end else begin
                    if (ack) begin
                        if (discard_m) begin
                            discard_m = 1'b0;
                            exp_issue = 1'b1;
                        end else begin
                            occ++;
                            exp_fetch++;
                        end
                    end
                    if ((occ - (ack && !discard_m ? 0 : 0)) != 0 && Ready_i && CmdValid_o) begin
                        occ--;
                        exp_pc++;
                    end
                end
            end
            prev_pend = MemReq_o && !MemAck_i;
            prev_addr = MemAddr_o;
        end
    end

    // Wrap instance: 4-bit addresses starting at E, zero-wait memory.
    always @(negedge clk) begin
        if (!rst) begin
            if (w_valid && Ready_i) begin
                chk("wrap_pc", w_pc, w_exp_pc);
                chk("wrap_cmd", w_cmd, {4'h0, w_exp_pc} + 8'd1);
                w_exp_pc++;
            end
            if (w_req) begin
                chk("wrap_addr", w_addr, w_exp_fetch);
                w_exp_fetch++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        @(posedge clk);
        #1;
        rst = 1'b1; Halt_i = 1'b0; Jump_i = 1'b0; sp_ack = 1'b0;
        exp_pc = 8'h00; exp_fetch = 8'h00; occ = 0;
        halted_m = 1'b0; drain = 1'b0; discard_m = 1'b0; exp_issue = 1'b0;
        prev_pend = 1'b0; prev_addr = 8'h00;
        w_exp_pc = 4'hE; w_exp_fetch = 4'hE;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        req_cnt = 0;
    endtask

    // Step until a request has just been issued (bounded).
    task automatic wait_fresh_req();
        bit seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            step();
            if (MemReq_o && wcnt == 0 && !MemAck_i) seen = 1'b1;
        end
        if (!seen) chk("wait_req_timeout", 0, 1);
    endtask

    initial begin
        // Zero-wait stream
        fix_lat = 0; Ready_i = 1'b0;
        reset_dut();
        chk("rst_cmd", Cmd_o, 8'h00);
        chk("rst_valid", CmdValid_o, 0);
        chk("rst_pc", Pc_o, 8'h00);
        chk("rst_halted", Halted_o, 0);
        chk("rst_req", MemReq_o, 0);
        chk("rst_addr", MemAddr_o, 8'h00);
        step();
        chk("first_req", MemReq_o, 1);
        chk("first_addr", MemAddr_o, 8'h00);
        Ready_i = 1'b1;
        step();
        for (int i = 0; i < 30; i++) begin
            chk("stream_valid", CmdValid_o, 1);
            step();
        end

        // Back-pressure: exactly DEPTH requests, then idle, then resume
        Ready_i = 1'b0;
        reset_dut();
        repeat (10) step();
        chk("stall_reqs", req_cnt, DEPTH);
        chk("stall_idle", MemReq_o, 0);
        Ready_i = 1'b1;
        repeat (20) step();

        // Slow memory
        fix_lat = 3;
        reset_dut();
        repeat (40) step();

        // Halt while a request is pending
        reset_dut();
        repeat (10) step();
        wait_fresh_req();
        Halt_i = 1'b1;
        step();
        Halt_i = 1'b0;
        chk("halt_flag", Halted_o, 1);
        chk("halt_drain", MemReq_o, 1);
        chk("halt_flush", CmdValid_o, 0);
        repeat (10) step();
        chk("halt_idle", MemReq_o, 0);
        reset_dut();
        step();
        chk("restart_req", MemReq_o, 1);
        chk("restart_addr", MemAddr_o, 8'h00);

`ifdef CMD_FETCH_JUMP_EN
        // Jump during an outstanding fetch
        reset_dut();
        repeat (6) step();
        wait_fresh_req();
        Jump_i = 1'b1; JumpAddr_i = 8'h40;
        step();
        Jump_i = 1'b0;
        begin
            bit got = 1'b0;
            for (int i = 0; i < 20 && !got; i++) begin
                if (CmdValid_o) got = 1'b1;
                else step();
            end
            if (!got) chk("jump_timeout", 0, 1);
            chk("jump_cmd", Cmd_o, 8'h41);
            chk("jump_pc", Pc_o, 8'h40);
        end
        repeat (10) step();
`endif

        // Randomized traffic with spurious acks, occasional halts/jumps
        rand_mode = 1'b1;
        for (int r = 0; r < 6; r++) begin
            reset_dut();
            for (int c = 0; c < 400; c++) begin
                Ready_i = ($urandom_range(0, 2) != 0);
                sp_ack  = ($urandom_range(0, 3) == 0);
                Halt_i  = ($urandom_range(0, 299) == 0);
`ifdef CMD_FETCH_JUMP_EN
                Jump_i     = ($urandom_range(0, 39) == 0);
                JumpAddr_i = 8'($urandom_range(0, 255));
`endif
                step();
            end
            Halt_i = 1'b0;
            Jump_i = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
